// File: rtl/sort_seq_ctrl_pkg.sv
// Shared types and constants for the sequential odd-even transposition sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_VALS = 8;
    localparam int unsigned DEF_WIDTH    = 4;

    // MSB bit position of element i; element 0 sits at the top of the vector.
    function automatic int unsigned elem_idx(input int unsigned i,
                                             input int unsigned n = DEF_NUM_VALS,
                                             input int unsigned w = DEF_WIDTH);
        return n * w - 1 - i * w;
    endfunction

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// Valid/ready front and back end of the sorter, plus its abort and status lines.
interface sort_seq_ctrl_if
    import sort_pkg::*;
#(
    parameter int unsigned NUM_VALS = DEF_NUM_VALS,
    parameter int unsigned WIDTH    = DEF_WIDTH
);
    logic                      clr;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_VALS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_VALS*WIDTH-1:0] out_data;
    logic                      busy;

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sort_seq_ctrl_cmp_swap.sv
// Combinational compare-exchange: lo goes to the lower element index, hi to the higher.
module cmp_swap
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter bit          ASCEND = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic swap;

    // Strict compare so equal elements never move.
    assign swap = ASCEND ? (a > b) : (a < b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;
endmodule

// File: rtl/sort_seq_ctrl.sv
// Clocked sort engine: one odd-even transposition phase per cycle, NUM_VALS phases,
// with valid/ready handshakes on the input and on the registered output.
module sort_seq_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned NUM_VALS = DEF_NUM_VALS,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter bit          ASCEND   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    sort_seq_ctrl_if.slave  bus
);
    localparam int unsigned DW = NUM_VALS * WIDTH;
    localparam int unsigned NP = NUM_VALS / 2;
    localparam int unsigned CW = $clog2(NUM_VALS) + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   work, work_nxt, phased;

    logic [WIDTH-1:0] cur  [NUM_VALS];
    logic [WIDTH-1:0] nxt  [NUM_VALS];
    logic [WIDTH-1:0] a_v  [NP];
    logic [WIDTH-1:0] b_v  [NP];
    logic [WIDTH-1:0] lo_v [NP];
    logic [WIDTH-1:0] hi_v [NP];

    genvar e, p;

    generate
        for (e = 0; e < NUM_VALS; e++) begin : g_unpack
            assign cur[e] = work[elem_idx(e, NUM_VALS, WIDTH) -: WIDTH];
            assign phased[elem_idx(e, NUM_VALS, WIDTH) -: WIDTH] = nxt[e];
        end

        // Comparator p serves pair (2p,2p+1) on even phases and (2p+1,2p+2) on odd ones.
        for (p = 0; p < NP; p++) begin : g_pair
            if (2 * p + 2 < NUM_VALS) begin : g_shared
                assign a_v[p] = cnt[0] ? cur[2*p+1] : cur[2*p];
                assign b_v[p] = cnt[0] ? cur[2*p+2] : cur[2*p+1];
            end else begin : g_even_only
                assign a_v[p] = cur[2*p];
                assign b_v[p] = cur[2*p+1];
            end

            cmp_swap #(.WIDTH(WIDTH), .ASCEND(ASCEND)) u_cs (
                .a  (a_v[p]),
                .b  (b_v[p]),
                .lo (lo_v[p]),
                .hi (hi_v[p])
            );
        end

        // Route each element from its comparator for the current phase, or pass it through.
        for (e = 0; e < NUM_VALS; e++) begin : g_route
            if (e % 2 == 0) begin : g_even_elem
                if (e + 1 < NUM_VALS && e >= 2) begin : g_both
                    assign nxt[e] = cnt[0] ? hi_v[(e-2)/2] : lo_v[e/2];
                end else if (e + 1 < NUM_VALS) begin : g_even_pair
                    assign nxt[e] = cnt[0] ? cur[e] : lo_v[e/2];
                end else if (e >= 2) begin : g_odd_pair
                    assign nxt[e] = cnt[0] ? hi_v[(e-2)/2] : cur[e];
                end else begin : g_none
                    assign nxt[e] = cur[e];
                end
            end else begin : g_odd_elem
                if (e + 1 < NUM_VALS) begin : g_both
                    assign nxt[e] = cnt[0] ? lo_v[e/2] : hi_v[e/2];
                end else begin : g_even_pair
                    assign nxt[e] = cnt[0] ? cur[e] : hi_v[e/2];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        if (bus.clr) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work_nxt  = bus.in_data;
                        cnt_nxt   = '0;
                        state_nxt = S_SORT;
                    end
                end
                S_SORT: begin
                    work_nxt = phased;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == CW'(NUM_VALS - 1)) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_SORT);
    assign bus.out_data  = work;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed and scoreboarded checks of sort_seq_ctrl (ascending) plus a descending instance.
module tb_sort_seq_ctrl;
    import sort_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned DW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sort_seq_ctrl_if #(.NUM_VALS(N), .WIDTH(W)) bus   ();
    sort_seq_ctrl_if #(.NUM_VALS(N), .WIDTH(W)) bus_d ();

    sort_seq_ctrl #(.NUM_VALS(N), .WIDTH(W), .ASCEND(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sort_seq_ctrl #(.NUM_VALS(N), .WIDTH(W), .ASCEND(1'b0)) dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain selection sort over the element list.
    function automatic logic [DW-1:0] sort_ref(input logic [DW-1:0] v, input bit asc);
        logic [W-1:0]  el [N];
        logic [W-1:0]  t;
        logic [DW-1:0] r;
        for (int unsigned i = 0; i < N; i++) el[i] = v[DW-1-i*W -: W];
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = i + 1; j < N; j++)
                if (asc ? (el[j] < el[i]) : (el[j] > el[i])) begin
                    t = el[i]; el[i] = el[j]; el[j] = t;
                end
        r = '0;
        for (int unsigned i = 0; i < N; i++) r[DW-1-i*W -: W] = el[i];
        return r;
    endfunction

    task automatic run_vec(input string tag, input logic [DW-1:0] din, input logic [DW-1:0] exp);
        int cyc;
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1({tag, "_back_idle"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int            cyc, busy_cnt, sent, recv;
        logic          seen, hs_in;
        logic [DW-1:0] q [$];

        bus.clr = 1'b0;   bus.in_valid = 1'b0;   bus.in_data = '0;   bus.out_ready = 1'b0;
        bus_d.clr = 1'b0; bus_d.in_valid = 1'b0; bus_d.in_data = '0; bus_d.out_ready = 1'b0;

        // Async reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready",  bus.in_ready,  1'b1);
        chk1("rst_busy",      bus.busy,      1'b0);
        chk ("rst_out_data",  bus.out_data,  '0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic sort: latency and busy window
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7316_2540;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!bus.out_valid && cyc < 30) begin
            busy_cnt += int'(bus.busy);
            tick();
            cyc++;
        end
        chk ("basic_latency",   cyc,          8);
        chk ("basic_busy_cnt",  busy_cnt,     8);
        chk1("basic_busy_done", bus.busy,     1'b0);
        chk ("basic_data",      bus.out_data, 32'h0123_4567);

        // Stall in DONE with a competing input
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk ("stall_data",      bus.out_data,  32'h0123_4567);
            chk1("stall_in_ready",  bus.in_ready,  1'b0);
            chk1("stall_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1("release_out_valid", bus.out_valid, 1'b0);
        chk1("release_in_ready",  bus.in_ready,  1'b1);
        chk1("release_busy",      bus.busy,      1'b0);

        // Data patterns
        run_vec("swap_halves", 32'hFFFF_0000, 32'h0000_FFFF);
        run_vec("all_equal",   32'h5555_5555, 32'h5555_5555);
        run_vec("reverse",     32'hFEDC_BA98, 32'h89AB_CDEF);

        // Descending instance
        bus_d.in_valid = 1'b1;
        bus_d.in_data  = 32'h0123_4567;
        tick();
        bus_d.in_valid = 1'b0;
        cyc = 0;
        while (!bus_d.out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("desc_latency", cyc,            8);
        chk("desc_data",    bus_d.out_data, 32'h7654_3210);
        bus_d.out_ready = 1'b1;
        tick();
        bus_d.out_ready = 1'b0;

        // clr in third SORT cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7316_2540;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk1("clr_pre_busy", bus.busy, 1'b1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk1("clr_in_ready",  bus.in_ready,  1'b1);
        chk1("clr_busy",      bus.busy,      1'b0);
        chk1("clr_out_valid", bus.out_valid, 1'b0);
        seen = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            seen |= bus.out_valid;
        end
        chk1("clr_never_valid", seen, 1'b0);

        // clr beats a simultaneous input handshake
        bus.in_valid = 1'b1;
        bus.clr      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        chk1("clr_blocks_accept", bus.busy, 1'b0);

        // Async reset in fourth SORT cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7316_2540;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk1("arst_in_ready",  bus.in_ready,  1'b1);
        chk1("arst_busy",      bus.busy,      1'b0);
        chk1("arst_out_valid", bus.out_valid, 1'b0);
        chk ("arst_out_data",  bus.out_data,  '0);
        #2 rst = 1'b0;
        run_vec("post_rst", 32'h9A3C_05E1, 32'h0135_9ACE);

        // Random stream against the reference queue
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 1000 || recv < 1000) && cyc < 60000) begin
            if (!bus.in_valid && sent < 1000 && $urandom_range(3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            hs_in = bus.in_valid && bus.in_ready;
            if (hs_in) begin
                q.push_back(sort_ref(bus.in_data, 1'b1));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) chk("stream_data", bus.out_data, q.pop_front());
                else              chk("stream_spurious", bus.out_data, 'x);
                recv++;
            end
            tick();
            cyc++;
            if (hs_in) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_sent",  sent,     1000);
        chk("stream_recv",  recv,     1000);
        chk("stream_left",  q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
